// File: rtl/pa_clk_lpmd_if.sv
// Low-power-mode handshake bundle between the core side (master) and the
// clock-enable sequencer (slave).
interface pa_clk_lpmd_if;
    logic       cp0_lpmd_req;
    logic [1:0] cp0_lpmd_type;
    logic       biu_lpmd_idle;
    logic       lsu_lpmd_idle;
    logic       intr_wakeup;
    logic       dbg_wakeup;
    logic       clk_en;
    logic       lpmd_ack;
    logic       lpmd_wake_done;
    logic [1:0] sysio_pad_lpmd;
    logic       lpmd_abort;

    modport master (
        output cp0_lpmd_req,
        output cp0_lpmd_type,
        output biu_lpmd_idle,
        output lsu_lpmd_idle,
        output intr_wakeup,
        output dbg_wakeup,
        input  clk_en,
        input  lpmd_ack,
        input  lpmd_wake_done,
        input  sysio_pad_lpmd,
        input  lpmd_abort
    );

    modport slave (
        input  cp0_lpmd_req,
        input  cp0_lpmd_type,
        input  biu_lpmd_idle,
        input  lsu_lpmd_idle,
        input  intr_wakeup,
        input  dbg_wakeup,
        output clk_en,
        output lpmd_ack,
        output lpmd_wake_done,
        output sysio_pad_lpmd,
        output lpmd_abort
    );
endinterface

// File: rtl/pa_clk_lpmd_ctrl.sv
// Low-power-mode sequencer for the core clock enable.
// RUN -> DRAIN (wait for BIU/LSU idle) -> GATED (clk_en low) -> WAKE (settle)
// -> RUN. Clocked by the ungated forever_cpuclk so it keeps running while the
// core clock is stopped. All outputs are registered.
// Optional drain timeout: define PA_LPMD_DRAIN_TMO_EN to abort a DRAIN that
// has not gone idle within DRAIN_TMO non-idle cycles.
module pa_clk_lpmd_ctrl #(
    parameter int WAKE_DLY  = 4,
    parameter int DRAIN_TMO = 255
) (
    input  logic          forever_cpuclk,
    input  logic          cpurst,
    pa_clk_lpmd_if.slave  lpmd
);

    // Elaboration-time parameter range guards.
    if (WAKE_DLY < 1 || WAKE_DLY > 15) begin : g_bad_wake_dly
        $error("pa_clk_lpmd_ctrl: WAKE_DLY must be 1..15");
    end
    if (DRAIN_TMO < 1 || DRAIN_TMO > 255) begin : g_bad_drain_tmo
        $error("pa_clk_lpmd_ctrl: DRAIN_TMO must be 1..255");
    end

    localparam logic [3:0] WAKE_LOAD = 4'(WAKE_DLY);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] lpmd_type_reg, lpmd_type_next;
    logic [3:0] wake_cnt_reg, wake_cnt_next;
    logic       req_armed_reg, req_armed_next;

    logic       clk_en_reg, clk_en_next;
    logic       ack_reg, ack_next;
    logic       wake_done_reg, wake_done_next;
    logic [1:0] pad_reg, pad_next;
    logic       abort_next;

    logic       wakeup;
    logic       idle;
    logic       req_go;
    logic       drain_tmo_hit;

    assign wakeup = lpmd.intr_wakeup | lpmd.dbg_wakeup;
    assign idle   = lpmd.biu_lpmd_idle & lpmd.lsu_lpmd_idle;
    // Reserved type 11 and a request still held after its ack never start a drain.
    assign req_go = lpmd.cp0_lpmd_req & req_armed_reg &
                    (lpmd.cp0_lpmd_type != 2'b11) & ~wakeup;

`ifdef PA_LPMD_DRAIN_TMO_EN
    logic [7:0] drain_cnt_reg, drain_cnt_next;
    logic       abort_reg;

    // Timeout fires in the cycle whose non-idle tick would make the count reach
    // DRAIN_TMO, so an all-busy DRAIN lasts exactly DRAIN_TMO cycles.
    assign drain_tmo_hit = (({1'b0, drain_cnt_reg} + 9'd1) == 9'(DRAIN_TMO));

    // Drain counter: cleared on DRAIN entry, counts non-idle DRAIN cycles, saturates.
    always_comb begin
        drain_cnt_next = drain_cnt_reg;
        if (state_reg == ST_RUN && state_next == ST_DRAIN) begin
            drain_cnt_next = 8'd0;
        end else if (state_reg == ST_DRAIN && !idle && drain_cnt_reg != 8'hFF) begin
            drain_cnt_next = drain_cnt_reg + 8'd1;
        end
    end

    // Drain counter and abort pulse registers.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            drain_cnt_reg <= 8'd0;
            abort_reg     <= 1'b0;
        end else begin
            drain_cnt_reg <= drain_cnt_next;
            abort_reg     <= abort_next;
        end
    end

    assign lpmd.lpmd_abort = abort_reg;
`else
    assign drain_tmo_hit   = 1'b0;
    assign lpmd.lpmd_abort = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_reg     <= ST_RUN;
            lpmd_type_reg <= 2'b00;
            wake_cnt_reg  <= 4'd0;
            req_armed_reg <= 1'b1;
            clk_en_reg    <= 1'b1;
            ack_reg       <= 1'b0;
            wake_done_reg <= 1'b0;
            pad_reg       <= 2'b00;
        end else begin
            state_reg     <= state_next;
            lpmd_type_reg <= lpmd_type_next;
            wake_cnt_reg  <= wake_cnt_next;
            req_armed_reg <= req_armed_next;
            clk_en_reg    <= clk_en_next;
            ack_reg       <= ack_next;
            wake_done_reg <= wake_done_next;
            pad_reg       <= pad_next;
        end
    end

    // Next-state logic, type latch and wake settle counter.
    always_comb begin
        state_next     = state_reg;
        lpmd_type_next = lpmd_type_reg;
        wake_cnt_next  = wake_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (req_go) begin
                    state_next     = ST_DRAIN;
                    lpmd_type_next = lpmd.cp0_lpmd_type;
                end
            end
            ST_DRAIN: begin
                // Wakeup beats idle, idle beats timeout.
                if (wakeup) begin
                    state_next = ST_RUN;
                end else if (idle) begin
                    state_next = ST_GATED;
                end else if (drain_tmo_hit) begin
                    state_next = ST_RUN;
                end
            end
            ST_GATED: begin
                if (wakeup) begin
                    state_next    = ST_WAKE;
                    wake_cnt_next = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Wakeup inputs are ignored here; only the settle count matters.
                wake_cnt_next = wake_cnt_reg - 4'd1;
                if (wake_cnt_reg <= 4'd1) begin
                    state_next    = ST_RUN;
                    wake_cnt_next = 4'd0;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Registered-output next values, derived from the transition being taken.
    always_comb begin
        clk_en_next    = (state_next != ST_GATED);
        ack_next       = (state_reg == ST_DRAIN) && (state_next == ST_GATED);
        wake_done_next = (state_next == ST_RUN) &&
                         ((state_reg == ST_WAKE) || (state_reg == ST_DRAIN && wakeup));
        abort_next     = (state_reg == ST_DRAIN) && !wakeup && !idle && drain_tmo_hit;
        pad_next       = ((state_next == ST_GATED) || (state_next == ST_WAKE)) ?
                         lpmd_type_next : 2'b00;
        // Re-arm once the request is seen low; ack or abort disarm and win.
        req_armed_next = req_armed_reg;
        if (!lpmd.cp0_lpmd_req) begin
            req_armed_next = 1'b1;
        end
        if (ack_next || abort_next) begin
            req_armed_next = 1'b0;
        end
    end

    assign lpmd.clk_en         = clk_en_reg;
    assign lpmd.lpmd_ack       = ack_reg;
    assign lpmd.lpmd_wake_done = wake_done_reg;
    assign lpmd.sysio_pad_lpmd = pad_reg;

endmodule

// File: tb/tb_pa_clk_lpmd_ctrl.sv
// Self-checking bench for pa_clk_lpmd_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
// Build with +define+PA_LPMD_DRAIN_TMO_EN to also exercise the drain timeout.
module tb_pa_clk_lpmd_ctrl;

    localparam int P_WAKE = 4;
    localparam int P_TMO  = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pa_clk_lpmd_if lpmd_bus ();

    pa_clk_lpmd_ctrl #(
        .WAKE_DLY  (P_WAKE),
        .DRAIN_TMO (P_TMO)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .lpmd           (lpmd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    // mode: "run", "drain", "gated", "wake" held as small ints for clarity.
    localparam int M_RUN = 0, M_DRAIN = 1, M_GATED = 2, M_WAKE = 3;
    int         m_mode;
    logic [1:0] m_type;
    bit         m_armed;
    int         m_left;    // WAKE cycles still to spend
    int         m_busy;    // non-idle DRAIN cycles seen so far
    logic       e_clk, e_ack, e_done, e_abort;
    logic [1:0] e_pad;

    task automatic model_step();
        bit wake, idle, armed_n;
        if (rst) begin
            m_mode = M_RUN; m_type = 2'b00; m_armed = 1; m_left = 0; m_busy = 0;
            e_ack = 0; e_done = 0; e_abort = 0;
        end else begin
            wake = lpmd_bus.intr_wakeup | lpmd_bus.dbg_wakeup;
            idle = lpmd_bus.biu_lpmd_idle & lpmd_bus.lsu_lpmd_idle;
            e_ack = 0; e_done = 0; e_abort = 0;
            armed_n = lpmd_bus.cp0_lpmd_req ? m_armed : 1'b1;
            case (m_mode)
                M_RUN: if (lpmd_bus.cp0_lpmd_req && m_armed &&
                           lpmd_bus.cp0_lpmd_type != 2'b11 && !wake) begin
                    m_mode = M_DRAIN; m_type = lpmd_bus.cp0_lpmd_type; m_busy = 0;
                end
                M_DRAIN: begin
                    if (wake) begin
                        m_mode = M_RUN; e_done = 1;
                    end else if (idle) begin
                        m_mode = M_GATED; e_ack = 1; armed_n = 0;
                    end else begin
`ifdef PA_LPMD_DRAIN_TMO_EN
                        m_busy++;
                        if (m_busy == P_TMO) begin
                            m_mode = M_RUN; e_abort = 1; armed_n = 0;
                        end
`endif
                    end
                end
                M_GATED: if (wake) begin
                    m_mode = M_WAKE; m_left = P_WAKE;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_RUN; e_done = 1;
                    end
                end
            endcase
            m_armed = armed_n;
        end
        e_clk = (m_mode != M_GATED);
        e_pad = (m_mode == M_GATED || m_mode == M_WAKE) ? m_type : 2'b00;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic q, input logic [1:0] t,
                         input logic b, input logic l, input logic i, input logic d);
        rst                    = r;
        lpmd_bus.cp0_lpmd_req  = q;
        lpmd_bus.cp0_lpmd_type = t;
        lpmd_bus.biu_lpmd_idle = b;
        lpmd_bus.lsu_lpmd_idle = l;
        lpmd_bus.intr_wakeup   = i;
        lpmd_bus.dbg_wakeup    = d;
    endtask

    // One clock: advance the model on the edge, compare every output 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model_clk_en", 8'(lpmd_bus.clk_en), 8'(e_clk));
        check("model_ack", 8'(lpmd_bus.lpmd_ack), 8'(e_ack));
        check("model_wake_done", 8'(lpmd_bus.lpmd_wake_done), 8'(e_done));
        check("model_pad", 8'(lpmd_bus.sysio_pad_lpmd), 8'(e_pad));
        check("model_abort", 8'(lpmd_bus.lpmd_abort), 8'(e_abort));
    endtask

    typedef struct packed {
        logic       rst, req;
        logic [1:0] typ;
        logic       biu, lsu, intr, dbg;
        logic       clk_en, ack, done;
        logic [1:0] pad;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int  n;
        bit  seen;
        checks = 0;
        errors = 0;
        drive(1, 0, 0, 0, 0, 0, 0);

        // Reset hold, then a full sleep/wake round trip (type 01, WAKE_DLY 4).
        //               rst req typ  biu lsu int dbg | clk ack done pad
        tbl[0]  = '{1'b1,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,2'd0};
        tbl[1]  = '{1'b1,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,2'd0};
        tbl[2]  = '{1'b1,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,2'd0};
        tbl[3]  = '{1'b0,1'b1,2'd1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,2'd0}; // DRAIN
        tbl[4]  = '{1'b0,1'b1,2'd1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,2'd1}; // GATED
        tbl[5]  = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd1};
        tbl[6]  = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,2'd1}; // WAKE
        tbl[7]  = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,2'd1};
        tbl[8]  = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,2'd1};
        tbl[9]  = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,2'd1};
        tbl[10] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,2'd0}; // RUN
        tbl[11] = '{1'b0,1'b0,2'd1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,2'd0};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].typ, tbl[i].biu, tbl[i].lsu,
                  tbl[i].intr, tbl[i].dbg);
            cycle();
            check("vec_clk_en", 8'(lpmd_bus.clk_en), 8'(tbl[i].clk_en));
            check("vec_ack", 8'(lpmd_bus.lpmd_ack), 8'(tbl[i].ack));
            check("vec_wake_done", 8'(lpmd_bus.lpmd_wake_done), 8'(tbl[i].done));
            check("vec_pad", 8'(lpmd_bus.sysio_pad_lpmd), 8'(tbl[i].pad));
            $display("vec %0d clk_en=%0b ack=%0b done=%0b pad=%0d", i, lpmd_bus.clk_en,
                     lpmd_bus.lpmd_ack, lpmd_bus.lpmd_wake_done, lpmd_bus.sysio_pad_lpmd);
        end

        // Busy drain cancelled by debug wakeup: clock never stops, no ack.
        drive(0, 1, 2, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("drain_busy_clk_en", 8'(lpmd_bus.clk_en), 8'd1);
            check("drain_busy_ack", 8'(lpmd_bus.lpmd_ack), 8'd0);
        end
        drive(0, 1, 2, 0, 1, 0, 1);
        cycle();
        check("dbg_cancel_done", 8'(lpmd_bus.lpmd_wake_done), 8'd1);
        check("dbg_cancel_clk_en", 8'(lpmd_bus.clk_en), 8'd1);
        $display("seq dbg_cancel done=%0b", lpmd_bus.lpmd_wake_done);
        drive(0, 0, 0, 1, 1, 0, 0);
        cycle();

        // Wakeup and idle together in DRAIN: wakeup wins. Then reserved type ignored.
        drive(0, 1, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 1, 0, 1, 1, 1, 0);
        cycle();
        check("wake_vs_idle_ack", 8'(lpmd_bus.lpmd_ack), 8'd0);
        check("wake_vs_idle_done", 8'(lpmd_bus.lpmd_wake_done), 8'd1);
        check("wake_vs_idle_clk_en", 8'(lpmd_bus.clk_en), 8'd1);
        $display("seq wake_vs_idle ack=%0b done=%0b", lpmd_bus.lpmd_ack, lpmd_bus.lpmd_wake_done);
        drive(0, 1, 3, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("type11_clk_en", 8'(lpmd_bus.clk_en), 8'd1);
            check("type11_ack", 8'(lpmd_bus.lpmd_ack), 8'd0);
        end

        // Held request after ack does not re-enter; a 1-cycle drop re-arms it.
        drive(0, 1, 2, 1, 1, 0, 0);
        cycle();
        cycle();
        check("rearm_first_ack", 8'(lpmd_bus.lpmd_ack), 8'd1);
        check("rearm_pad", 8'(lpmd_bus.sysio_pad_lpmd), 8'd2);
        drive(0, 1, 2, 1, 1, 1, 0);
        cycle();
        drive(0, 1, 2, 1, 1, 0, 0);
        for (int i = 0; i < P_WAKE; i++) cycle();
        check("rearm_wake_done", 8'(lpmd_bus.lpmd_wake_done), 8'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("held_req_clk_en", 8'(lpmd_bus.clk_en), 8'd1);
            check("held_req_pad", 8'(lpmd_bus.sysio_pad_lpmd), 8'd0);
        end
        drive(0, 0, 2, 1, 1, 0, 0);
        cycle();
        drive(0, 1, 2, 1, 1, 0, 0);
        cycle();
        cycle();
        check("rearm_second_ack", 8'(lpmd_bus.lpmd_ack), 8'd1);
        check("rearm_second_clk_en", 8'(lpmd_bus.clk_en), 8'd0);
        $display("seq rearm ack=%0b clk_en=%0b", lpmd_bus.lpmd_ack, lpmd_bus.clk_en);

        // Reset while GATED restores the clock at the next edge, no pulses.
        drive(1, 0, 0, 1, 1, 0, 0);
        cycle();
        check("rst_gated_clk_en", 8'(lpmd_bus.clk_en), 8'd1);
        check("rst_gated_pad", 8'(lpmd_bus.sysio_pad_lpmd), 8'd0);
        check("rst_gated_done", 8'(lpmd_bus.lpmd_wake_done), 8'd0);
        $display("seq rst_in_gated clk_en=%0b", lpmd_bus.clk_en);
        drive(0, 0, 0, 1, 1, 0, 0);
        cycle();

`ifdef PA_LPMD_DRAIN_TMO_EN
        // LSU never idles: abort after exactly DRAIN_TMO drain cycles.
        drive(0, 1, 1, 1, 0, 0, 0);
        cycle();
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            cycle();
            n++;
            if (lpmd_bus.lpmd_abort === 1'b1) seen = 1;
        end
        check("tmo_abort_seen", 8'(seen), 8'd1);
        check("tmo_abort_cycles", 8'(n), 8'(P_TMO));
        check("tmo_clk_en", 8'(lpmd_bus.clk_en), 8'd1);
        check("tmo_ack", 8'(lpmd_bus.lpmd_ack), 8'd0);
        $display("seq drain_timeout cycles=%0d", n);
        cycle();
        check("tmo_no_reentry_pad", 8'(lpmd_bus.sysio_pad_lpmd), 8'd0);
        drive(0, 0, 0, 1, 1, 0, 0);
        cycle();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 6),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 29) == 0));
            cycle();
            if (e_ack || e_done || e_abort)
                $display("rnd %0d ack=%0b done=%0b abort=%0b pad=%0d", i, lpmd_bus.lpmd_ack,
                         lpmd_bus.lpmd_wake_done, lpmd_bus.lpmd_abort, lpmd_bus.sysio_pad_lpmd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
